// File: rtl/delta_sigma_adc.sv
// First-order delta-sigma ADC front end: comparator sync, feedback bit and a 3rd-order CIC decimator
// producing saturated signed 16-bit PCM. Define DELTA_SIGMA_ADC_DC_BLOCK_EN to add a one-pole DC blocker.
module delta_sigma_adc #(
    parameter int DECIMATION = 64
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        sample_en_i,
    input  logic        cmp_i,
    output logic        fb_o,
    output logic [15:0] sample_o,
    output logic        valid_o
);

    localparam int LOG2R = $clog2(DECIMATION);
    localparam int W     = 3 * LOG2R + 2;
    localparam int SHIFT = 3 * LOG2R - 15;

    logic             sync1_q, sync2_q, bit_q;
    logic [W-1:0]     i1_q, i2_q, i3_q;
    logic [W-1:0]     d1_q, d2_q, d3_q;
    logic [LOG2R-1:0] phase_q;
    logic [1:0]       warm_q;

    logic [W-1:0]        x;
    logic [W-1:0]        c1, c2, c3;
    logic signed [W-1:0] scaled;
    logic signed [15:0]  s;
    logic                tick;
    logic                strobe;

    // Comparator is asynchronous; this chain runs every clock regardless of the bit-rate enable.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= cmp_i;
            sync2_q <= sync1_q;
        end
    end

    assign x      = {{(W-1){~bit_q}}, 1'b1};
    assign tick   = sample_en_i && (phase_q == LOG2R'(DECIMATION - 1));
    assign strobe = tick && (warm_q == 2'd3);

    assign c1     = i3_q - d1_q;
    assign c2     = c1 - d2_q;
    assign c3     = c2 - d3_q;
    assign scaled = $signed(c3) >>> SHIFT;

    // Bits above the 16-bit range must all match the sign bit, otherwise clip.
    always_comb begin
        s = scaled[15:0];
        if (!(&scaled[W-1:15]) && (|scaled[W-1:15])) begin
            s = scaled[W-1] ? 16'sh8000 : 16'sh7fff;
        end
    end

    // Integrators wrap modulo 2^W on purpose; the combs undo the wrap exactly.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            bit_q   <= 1'b0;
            i1_q    <= '0;
            i2_q    <= '0;
            i3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            phase_q <= '0;
            warm_q  <= 2'd0;
        end else if (sample_en_i) begin
            bit_q   <= sync2_q;
            i1_q    <= i1_q + x;
            i2_q    <= i2_q + i1_q;
            i3_q    <= i3_q + i2_q;
            phase_q <= phase_q + LOG2R'(1);
            if (tick) begin
                d1_q <= i3_q;
                d2_q <= c1;
                d3_q <= c2;
                if (warm_q != 2'd3) begin
                    warm_q <= warm_q + 2'd1;
                end
            end
        end
    end

    assign fb_o = bit_q;

`ifdef DELTA_SIGMA_ADC_DC_BLOCK_EN
    logic signed [15:0] s_prev_q, y_q;
    logic signed [17:0] y_next;
    logic signed [15:0] y_sat;
    logic               pend_q;

    // Blocker only sees settled samples, so warm-up transients never enter its state.
    always_comb begin
        y_next = $signed({{2{s[15]}}, s}) - $signed({{2{s_prev_q[15]}}, s_prev_q})
               + $signed({{2{y_q[15]}}, y_q}) - ($signed({{2{y_q[15]}}, y_q}) >>> 8);
        y_sat  = y_next[15:0];
        if (!(&y_next[17:15]) && (|y_next[17:15])) begin
            y_sat = y_next[17] ? 16'sh8000 : 16'sh7fff;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s_prev_q <= '0;
            y_q      <= '0;
            pend_q   <= 1'b0;
            sample_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            pend_q  <= strobe;
            valid_o <= pend_q;
            if (strobe) begin
                s_prev_q <= s;
                y_q      <= y_sat;
            end
            if (pend_q) begin
                sample_o <= y_q;
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sample_o <= '0;
            valid_o  <= 1'b0;
        end else begin
            valid_o <= strobe;
            if (strobe) begin
                sample_o <= s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_delta_sigma_adc.sv
// Bench for delta_sigma_adc (R=64, DC blocker off): behavioural CIC model by direct convolution
// with the triple-boxcar impulse response, checked every clock.
module tb_delta_sigma_adc;

  localparam int R  = 64;
  localparam int HL = 3 * R - 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        cmp = 1'b0;
  logic        fb;
  logic [15:0] sample;
  logic        valid;

  always #5 clk = ~clk;

  delta_sigma_adc #(.DECIMATION(R)) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .sample_en_i (sample_en),
    .cmp_i       (cmp),
    .fb_o        (fb),
    .sample_o    (sample),
    .valid_o     (valid)
  );

  int n_vec = 0;
  int n_err = 0;

  int  h[HL];
  bit  cmp_hist[$];
  int  xs[$];
  int  exp_q[$];
  bit  model_bit;
  int  exp_sample;
  int  tick_cnt;
  int  last_strobe;
  bit  check_iv;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Impulse response of three cascaded length-R boxcars.
  task automatic build_h();
    int t[2*R-1];
    foreach (t[i]) t[i] = 0;
    foreach (h[i]) h[i] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++) t[a+b]++;
    for (int k = 0; k < 2*R-1; k++)
      for (int d = 0; d < R; d++) h[k+d] += t[k];
  endtask

  // Output on the tick at enable index n: integrator/comb chain delays the input by 3 bit periods.
  function automatic int model_out(input int n);
    int acc = 0;
    int s;
    for (int k = 0; k < HL; k++) begin
      int idx = n - 3 - k;
      if (idx >= 0) acc += h[k] * xs[idx];
    end
    s = acc >>> 3;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic model_clear();
    cmp_hist.delete();
    xs.delete();
    exp_q.delete();
    model_bit   = 1'b0;
    exp_sample  = 0;
    tick_cnt    = 0;
    last_strobe = -1;
  endtask

  task automatic step(input bit en, input bit c);
    int  cc;
    int  j;
    bit  exp_valid = 1'b0;
    sample_en = en;
    cmp = c;
    @(posedge clk);
    cmp_hist.push_back(c);
    cc = cmp_hist.size() - 1;
    if (en) begin
      j = xs.size();
      xs.push_back(model_bit ? 1 : -1);
      model_bit = (cc >= 2) ? cmp_hist[cc-2] : 1'b0;
      if (j % R == R - 1) begin
        tick_cnt++;
        if (tick_cnt >= 4) begin
          exp_sample = model_out(j);
          exp_q.push_back(exp_sample);
          exp_valid = 1'b1;
        end
      end
    end
    #1;
    check("valid", valid, exp_valid);
    if (valid === 1'b1) begin
      check("strobe_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) check("strobe_sample", $signed(sample), exp_q.pop_front());
      if (check_iv && last_strobe >= 0) check("strobe_interval", cc - last_strobe, 4 * R);
      last_strobe = cc;
    end
    check("sample_hold", $signed(sample), exp_sample);
    check("fb", fb, model_bit);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sample_en = 1'b0;
    #1;
    check("rst_sample", $signed(sample), 0);
    check("rst_valid", valid, 0);
    check("rst_fb", fb, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    model_clear();
  endtask

  // pat[k] is the comparator level for the k-th bit period, repeating every len periods.
  task automatic run_pattern(input bit [3:0] pat, input int len, input int clocks);
    for (int i = 0; i < clocks; i++) step(i % 4 == 3, pat[(i / 4) % len]);
  endtask

  initial begin
    int cnt;
    int guard;
    build_h();
    model_clear();
    check_iv = 1'b0;
    #1;
    do_reset();

    // Steady high: ticks 1-3 silent, then clipped full scale.
    run_pattern(4'b0001, 1, 6 * 4 * R);
    check("steady_high", $signed(sample), 32767);
    check("steady_high_fb", fb, 1);

    // Steady low, with strobe spacing checked.
    do_reset();
    check_iv = 1'b1;
    run_pattern(4'b0000, 1, 6 * 4 * R);
    check_iv = 1'b0;
    check("steady_low", $signed(sample), -32768);

    do_reset();
    run_pattern(4'b0001, 2, 6 * 4 * R);
    check("duty_1_0", $signed(sample), 0);

    do_reset();
    run_pattern(4'b0111, 4, 6 * 4 * R);
    check("duty_1110", $signed(sample), 16384);

    // Random comparator and random enable density, including back-to-back enables.
    do_reset();
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));

    // Gating: comparator toggles with no enables; nothing observable moves.
    for (int i = 0; i < 1000; i++) step(1'b0, 1'($urandom_range(0, 1)));
    check("gated_sample", $signed(sample), exp_sample);

    // Mid-frame reset with phase counter at 37, then time to first strobe.
    guard = 0;
    while ((xs.size() % R) != 37 && guard < 4 * R) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("reach_phase_37", xs.size() % R, 37);
    do_reset();
    cnt = -1;
    for (int i = 0; i < 5 * 4 * R; i++) begin
      step(i % 4 == 3, 1'b1);
      if (valid === 1'b1 && cnt < 0) cnt = xs.size();
    end
    check("first_strobe_pulses", cnt, 4 * R);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/delta_sigma_adc.md
# delta_sigma_adc

First-order delta-sigma ADC front end with a 3rd-order CIC decimator: the receive-side counterpart to the audio delta-sigma DAC. An external comparator compares the analog input against an RC-filtered copy of `fb_o`. The block samples the comparator, drives the feedback bit, and decimates the 1-bit stream into signed 16-bit PCM samples with a one-cycle valid strobe. It sits in the audio path for the cassette/line input and is clocked from the system clock.

## Interface
- `DECIMATION`, default 64: oversampling ratio R. Must be a power of 2, 32..1024.
- `clk_i`  in  1: system clock.
- `reset_n_i`  in  1: asynchronous, active-low reset.
- `sample_en_i`  in  1: bit-rate clock enable. All state except the synchronizer advances only on edges where this input is high.
- `cmp_i`  in  1: comparator output. Asynchronous to `clk_i`.
- `fb_o`  out  1: feedback bit to the RC integrator. Registered.
- `sample_o`  out  16: signed PCM sample. Holds its value between strobes.
- `valid_o`  out  1: one-cycle pulse when `sample_o` updates.

## Operation
- Synchronizer: 2-flop chain on `cmp_i`. It runs every clock and is not gated by `sample_en_i`.
- Bit register: on each `sample_en_i`, `bit_q <= sync2`. `fb_o` equals `bit_q`.
- Input mapping: x = `bit_q ? +1 : -1`. `bit_q` resets to 0, so the first integrated value is -1.
- Internal width: W = 3·log2(R) + 2 bits (20 at R=64). Every accumulator uses two's-complement wrap-around with no saturation. This wrap is required for CIC correctness.
- Integrators: on each `sample_en_i`:
  - `i1 <= i1 + x`
  - `i2 <= i2 + i1`
  - `i3 <= i3 + i2`
  - All right-hand sides use pre-edge values.
- Phase counter: log2(R) bits, counts `sample_en_i` edges, 0..R-1. A decimation tick occurs on the `sample_en_i` edge where the counter equals R-1; the counter then wraps to 0.
- Comb stage: chained combinationally on a tick, using the pre-edge value of `i3`:
  - `c1 = i3 - d1`, `c2 = c1 - d2`, `c3 = c2 - d3`
  - Registers update as `d1 <= i3`, `d2 <= c1`, `d3 <= c2`.
- Scaling: `s = c3 >>> (3·log2(R) - 15)` (arithmetic shift), saturated to [-32768, 32767]. Full-scale +1 gives +32768, which saturates to 32767.
- Warm-up: a 2-bit tick counter suppresses `valid_o` on the first 3 ticks after reset. The first strobe comes on tick 4.
  - `sample_o` stays 0 until that first strobe.
  - Integrators and combs run normally during warm-up.
- Reset (any time, including mid-frame): all registers clear immediately and asynchronously. This includes the synchronizer, `bit_q`, integrators, combs, the phase counter and the warm-up counter. Warm-up restarts after release.
- `sample_en_i` asserted on consecutive clocks is legal. Each asserted clock counts as one bit period.

## Timing
- Reset values: `fb_o`=0, `sample_o`=0, `valid_o`=0.
- Latency from `cmp_i` to `fb_o`:
  - 2 clocks through the synchronizer.
  - Then the next `sample_en_i` edge.
- A change on `cmp_i` enters the integrators one `sample_en_i` later, via `bit_q`.
- On a tick edge, `sample_o` and `valid_o` update at that same edge. `valid_o` is high for exactly one clock, then low. This holds even if `sample_en_i` stays high.
- Decimated output rate is exactly one strobe per R `sample_en_i` pulses.
- Steady state: the output reflects a constant input from tick 4 onward. The CIC impulse response spans 3R-2 input bits.

## Configuration
- `DELTA_SIGMA_ADC_DC_BLOCK_EN` defined: adds a one-pole DC blocker after saturation.
  - `y[n] = s[n] - s[n-1] + y[n-1] - (y[n-1] >>> 8)`, computed in 18 bits and saturated to 16.
  - It updates on the tick. `sample_o` and `valid_o` are then registered one clock later, so latency is tick + 1 clock.
  - Blocker state resets to 0.
- Macro undefined: `sample_o` = `s` on the tick edge, and the blocker logic is absent.

## Test plan
All scenarios use R=64, `sample_en_i` every 4th clock, and the DC blocker off unless stated otherwise.
- Reset and steady high: hold `cmp_i`=1 → no strobe on ticks 1–3; tick 4 and all later ticks give `sample_o`=32767 with `fb_o`=1.
- Steady low: hold `cmp_i`=0 → from tick 4, `sample_o`=-32768, and each `valid_o` pulse is exactly 1 clock wide every 256 clocks.
- Duty patterns: drive `cmp_i` in the repeating pattern 1,0 → steady `sample_o`=0. Drive the repeating pattern 1,1,1,0 → steady `sample_o`=16384.
- Mid-frame reset: pulse `reset_n_i` low while the phase counter is 37 → outputs are 0 immediately; after release, the first strobe arrives exactly 4·64 `sample_en_i` pulses later.
- Gating: hold `sample_en_i` low for 1000 clocks while toggling `cmp_i` → no change to `fb_o`, `sample_o` or `valid_o`.
- `DELTA_SIGMA_ADC_DC_BLOCK_EN`: step `cmp_i` from the 1,0 pattern to constant 1 → `sample_o` jumps toward 32767, then decays toward 0. Strobes are 1 clock later than the tick.
